// File: rtl/video_raster_timing_if.sv
// Bus bundle for the raster timing core: CPU/pixel-pipeline controls in,
// counters, timing strobes, contention, interrupts and pen latches out.
interface video_raster_timing_if;
  logic       ce_pix;
  logic       soff;
  logic       full_contend;
  logic       paper;
  logic       line_we;
  logic [7:0] line_din;
  logic [1:0] int_ack;

  logic [8:0] hc;
  logic [8:0] vc;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       fetch_go;
  logic [4:0] col;
  logic       fetch_active;
  logic       io_contention;
  logic       mem_contention;
  logic [1:0] int_pending;
  logic       flash;
  logic [7:0] lpen;
  logic [7:0] hpen;

  // Bus glue / pixel pipeline side
  modport master (
    output ce_pix, soff, full_contend, paper, line_we, line_din, int_ack,
    input  hc, vc, hblank, vblank, hsync, vsync, fetch_go, col, fetch_active,
           io_contention, mem_contention, int_pending, flash, lpen, hpen
  );

  // Timing core side
  modport slave (
    input  ce_pix, soff, full_contend, paper, line_we, line_din, int_ack,
    output hc, vc, hblank, vblank, hsync, vsync, fetch_go, col, fetch_active,
           io_contention, mem_contention, int_pending, flash, lpen, hpen
  );
endinterface

// File: rtl/video_raster_timing.sv
// Parametrised raster timing core: pixel/line counters, blank/sync,
// fetch window, CPU contention, pen latches, flash counter and
// pending/acknowledge line and frame interrupts.
module video_raster_timing #(
  parameter int H_TOTAL        = 384,
  parameter int V_TOTAL        = 312,
  parameter int H_ACT_START    = 128,
  parameter int V_ACTIVE       = 192,
  parameter int HBLANK_ON      = 28,
  parameter int HSYNC_ON       = 44,
  parameter int HSYNC_OFF      = 76,
  parameter int HBLANK_OFF     = 108,
  parameter int VBLANK_ON      = 236,
  parameter int VSYNC_ON       = 240,
  parameter int VSYNC_OFF      = 244,
  parameter int VBLANK_OFF     = 260,
  parameter int VBLANK_HC_ON   = 28,
  parameter int VBLANK_HC_OFF  = 104,
  parameter int FRAME_INT_LINE = 244,
  parameter int CPU_SLOT       = 5,
  parameter int FLASH_BITS     = 5,
  parameter int INT_AUTOCLR    = 128
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  video_raster_timing_if.slave   bus
);

  localparam logic [8:0] HC_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] VC_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] HC_ACT    = 9'(H_ACT_START);
  localparam logic [8:0] VC_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] HB_ON     = 9'(HBLANK_ON);
  localparam logic [8:0] HB_OFF    = 9'(HBLANK_OFF);
  localparam logic [8:0] HS_ON     = 9'(HSYNC_ON);
  localparam logic [8:0] HS_OFF    = 9'(HSYNC_OFF);
  localparam logic [8:0] VB_ON     = 9'(VBLANK_ON);
  localparam logic [8:0] VB_OFF    = 9'(VBLANK_OFF);
  localparam logic [8:0] VS_ON     = 9'(VSYNC_ON);
  localparam logic [8:0] VS_OFF    = 9'(VSYNC_OFF);
  localparam logic [8:0] VB_HC_ON  = 9'(VBLANK_HC_ON);
  localparam logic [8:0] VB_HC_OFF = 9'(VBLANK_HC_OFF);
  localparam logic [8:0] VC_FINT   = 9'(FRAME_INT_LINE);
  localparam logic [2:0] SLOT      = 3'(CPU_SLOT);
  localparam logic [7:0] HPEN_OUT  = 8'(V_ACTIVE);
  localparam int         CNT_W     = (INT_AUTOCLR > 1) ? $clog2(INT_AUTOCLR + 1) : 1;
  localparam logic [CNT_W-1:0] AUTOCLR_N = CNT_W'(INT_AUTOCLR);

  logic [8:0]            hc_reg;
  logic [8:0]            vc_reg;
  logic [8:0]            vc_next;
  logic                  line_end;
  logic [FLASH_BITS-1:0] flash_reg;
  logic                  hblank_reg;
  logic                  hsync_reg;
  logic                  vblank_reg;
  logic                  vsync_reg;
  logic                  fetch_go;
  logic                  fetch_active_reg;
  logic [4:0]            col;
  logic                  io_contention;
  logic                  mem_contention;
  logic [7:0]            shadow_reg;
  logic [7:0]            active_reg;
  logic                  line_hit;
  logic [1:0]            set_req;
  logic [1:0]            pend_bits;
  logic [7:0]            lpen_reg;
  logic [7:0]            hpen_reg;

  assign line_end = (hc_reg == HC_LAST);
  assign vc_next  = (vc_reg == VC_LAST) ? 9'd0 : vc_reg + 9'd1;

  // Pixel/line counters and the frame-rate flash counter
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hc_reg    <= '0;
      vc_reg    <= '0;
      flash_reg <= '0;
    end else if (bus.ce_pix) begin
      if (line_end) begin
        hc_reg <= '0;
        vc_reg <= vc_next;
        if (vc_reg == VC_LAST) begin
          flash_reg <= flash_reg + 1'b1;
        end
      end else begin
        hc_reg <= hc_reg + 9'd1;
      end
    end
  end

  // Blank/sync flags, toggled on the pixel that hits each compare point
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hblank_reg <= 1'b0;
      hsync_reg  <= 1'b0;
      vblank_reg <= 1'b0;
      vsync_reg  <= 1'b0;
    end else if (bus.ce_pix) begin
      if (hc_reg == HB_ON) begin
        hblank_reg <= 1'b1;
      end else if (hc_reg == HB_OFF) begin
        hblank_reg <= 1'b0;
      end
      if (hc_reg == HS_ON) begin
        hsync_reg <= 1'b1;
      end else if (hc_reg == HS_OFF) begin
        hsync_reg <= 1'b0;
      end
      if (vc_reg == VB_ON && hc_reg == VB_HC_ON) begin
        vblank_reg <= 1'b1;
      end else if (vc_reg == VB_OFF && hc_reg == VB_HC_OFF) begin
        vblank_reg <= 1'b0;
      end
      // vsync follows the line boundary, so it changes as vc enters the line
      if (line_end && vc_next == VS_ON) begin
        vsync_reg <= 1'b1;
      end else if (line_end && vc_next == VS_OFF) begin
        vsync_reg <= 1'b0;
      end
    end
  end

  assign fetch_go = bus.ce_pix && (hc_reg >= HC_ACT) && (vc_reg < VC_ACT) &&
                    (hc_reg[2:0] == 3'd0) && !bus.soff;
  assign col      = {~hc_reg[7], hc_reg[6:3]};

  // Fetch window: opens on the first cell fetch, closes at the start of the line
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fetch_active_reg <= 1'b0;
    end else if (fetch_go) begin
      fetch_active_reg <= 1'b1;
    end else if (bus.ce_pix && hc_reg == 9'd0) begin
      fetch_active_reg <= 1'b0;
    end
  end

  // Contention: one CPU slot per cell in the window, 1-in-4 outside it
  always_comb begin
    io_contention  = (hc_reg[2:0] != SLOT);
    mem_contention = (fetch_active_reg | bus.full_contend) ? (hc_reg[2:0] != SLOT)
                                                           : (hc_reg[1:0] != SLOT[1:0]);
  end

  // Line compare: CPU writes the shadow, which takes effect at the next line start
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      shadow_reg <= 8'hFF;
      active_reg <= 8'hFF;
    end else begin
      if (bus.line_we) begin
        shadow_reg <= bus.line_din;
      end
      if (bus.ce_pix && line_end) begin
        active_reg <= shadow_reg;
      end
    end
  end

  assign line_hit   = ({1'b0, active_reg} < VC_ACT) && ({1'b0, active_reg} == vc_reg);
  assign set_req[0] = bus.ce_pix && (hc_reg == 9'd0) && line_hit;
  assign set_req[1] = bus.ce_pix && (hc_reg == 9'd0) && (vc_reg == VC_FINT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_int
      logic             pend_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Pending bit: set beats ack/auto-clear; counter measures pixels since set
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          pend_reg <= 1'b0;
          cnt_reg  <= '0;
        end else if (set_req[gi]) begin
          pend_reg <= 1'b1;
          cnt_reg  <= '0;
        end else if (bus.int_ack[gi]) begin
          pend_reg <= 1'b0;
        end else if (INT_AUTOCLR > 0 && pend_reg && bus.ce_pix) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg + CNT_W'(1) == AUTOCLR_N) begin
            pend_reg <= 1'b0;
          end
        end
      end

      assign pend_bits[gi] = pend_reg;
    end
  endgenerate

  // Light-pen latches, captured in the CPU slot of each cell
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lpen_reg <= '0;
      hpen_reg <= '0;
    end else if (bus.ce_pix && !io_contention) begin
      hpen_reg <= (bus.soff || vc_reg >= VC_ACT) ? HPEN_OUT : vc_reg[7:0];
      lpen_reg <= {(bus.paper ? col : 5'd0), 3'b000};
    end
  end

  assign bus.hc             = hc_reg;
  assign bus.vc             = vc_reg;
  assign bus.hblank         = hblank_reg;
  assign bus.vblank         = vblank_reg;
  assign bus.hsync          = hsync_reg;
  assign bus.vsync          = vsync_reg;
  assign bus.fetch_go       = fetch_go;
  assign bus.col            = col;
  assign bus.fetch_active   = fetch_active_reg;
  assign bus.io_contention  = io_contention;
  assign bus.mem_contention = mem_contention;
  assign bus.int_pending    = pend_bits;
  assign bus.flash          = flash_reg[FLASH_BITS-1];
  assign bus.lpen           = lpen_reg;
  assign bus.hpen           = hpen_reg;

endmodule

// File: tb/tb_video_raster_timing.sv
// Directed bench for video_raster_timing. Two instances run in lockstep on a
// short 20-line frame with the default horizontal timing: one auto-clears
// interrupts after 128 pixels, the other holds them until acknowledged.
module tb_video_raster_timing;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic       soff;
  logic       full_contend;
  logic       paper;
  logic       line_we;
  logic [7:0] line_din;
  logic [1:0] int_ack;

  int n_checks = 0;
  int n_errors = 0;
  int pos_h = 0;
  int pos_v = 0;
  int ce_div = 4;
  int go_cnt, go_first, go_last;
  logic go_seen;

  video_raster_timing_if bus_ac ();
  video_raster_timing_if bus_hold ();

  assign bus_ac.ce_pix         = ce_pix;
  assign bus_ac.soff           = soff;
  assign bus_ac.full_contend   = full_contend;
  assign bus_ac.paper          = paper;
  assign bus_ac.line_we        = line_we;
  assign bus_ac.line_din       = line_din;
  assign bus_ac.int_ack        = int_ack;
  assign bus_hold.ce_pix       = ce_pix;
  assign bus_hold.soff         = soff;
  assign bus_hold.full_contend = full_contend;
  assign bus_hold.paper        = paper;
  assign bus_hold.line_we      = line_we;
  assign bus_hold.line_din     = line_din;
  assign bus_hold.int_ack      = int_ack;

  video_raster_timing #(
    .V_TOTAL(20), .V_ACTIVE(12), .VBLANK_ON(14), .VSYNC_ON(15), .VSYNC_OFF(16),
    .VBLANK_OFF(17), .FRAME_INT_LINE(16), .FLASH_BITS(2), .INT_AUTOCLR(128)
  ) dut_ac (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus_ac)
  );

  video_raster_timing #(
    .V_TOTAL(20), .V_ACTIVE(12), .VBLANK_ON(14), .VSYNC_ON(15), .VSYNC_OFF(16),
    .VBLANK_OFF(17), .FRAME_INT_LINE(16), .FLASH_BITS(1), .INT_AUTOCLR(0)
  ) dut_hold (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus_hold)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One pixel: ce_div-1 idle clocks, then a clock with ce_pix high
  task automatic pix(input logic [1:0] ack);
    for (int i = 1; i < ce_div; i++) begin
      @(posedge clk_sys); #1;
    end
    ce_pix  = 1'b1;
    int_ack = ack;
    #1;
    go_seen = bus_ac.fetch_go;
    if (go_seen) begin
      go_cnt++;
      if (go_first < 0) go_first = pos_h;
      go_last = pos_h;
    end
    @(posedge clk_sys); #1;
    ce_pix  = 1'b0;
    int_ack = 2'b00;
    if (pos_h == 383) begin
      pos_h = 0;
      pos_v = (pos_v == 19) ? 0 : pos_v + 1;
    end else begin
      pos_h++;
    end
  endtask

  task automatic goto(input int h, input int v);
    int guard = 0;
    while (!(pos_h == h && pos_v == v) && guard < 20000) begin
      pix(2'b00);
      guard++;
    end
    check("pos_ac", {7'd0, bus_ac.vc, 7'd0, bus_ac.hc}, {v[15:0], h[15:0]});
    check("pos_hold", {7'd0, bus_hold.vc, 7'd0, bus_hold.hc}, {v[15:0], h[15:0]});
  endtask

  task automatic write_line(input logic [7:0] v);
    line_din = v;
    line_we  = 1'b1;
    @(posedge clk_sys); #1;
    line_we  = 1'b0;
  endtask

  task automatic ack(input logic [1:0] v);
    int_ack = v;
    @(posedge clk_sys); #1;
    int_ack = 2'b00;
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, hb_cnt, mz_low, mz_win, io_z, fz;
    reset = 1'b1; ce_pix = 1'b0; soff = 1'b0; full_contend = 1'b0; paper = 1'b0;
    line_we = 1'b0; line_din = 8'd0; int_ack = 2'b00;
    go_cnt = 0; go_first = -1; go_last = -1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_hc", bus_ac.hc, 0);
    check("rst_vc", bus_ac.vc, 0);
    check("rst_sync", {bus_ac.hblank, bus_ac.hsync, bus_ac.vblank, bus_ac.vsync}, 0);
    check("rst_fa", bus_ac.fetch_active, 0);
    check("rst_int", bus_ac.int_pending, 0);
    check("rst_pen", {bus_ac.lpen, bus_ac.hpen}, 0);
    check("rst_flash", bus_hold.flash, 0);
    reset = 1'b0;
    @(posedge clk_sys); #1;
    check("ce_gate_hc", bus_ac.hc, 0);

    // Line 0, ce every 4 clocks: horizontal timing, fetch pulses, contention
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_cnt = 0; mz_low = 0; mz_win = 0; io_z = 0;
    for (int k = 0; k < 384; k++) begin
      pix(2'b00);
      if (k == 0) check("ce_step_hc", bus_ac.hc, 1);
      if (pos_v == 0) begin
        if (bus_ac.hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = pos_h;
          hs_last = pos_h;
        end
        if (bus_ac.hblank) hb_cnt++;
        if (pos_h <= 127 && !bus_ac.mem_contention) mz_low++;
        if (pos_h >= 136 && !bus_ac.mem_contention) mz_win++;
        if (!bus_ac.io_contention) io_z++;
        if (pos_h == 383) check("fa_line_end", bus_ac.fetch_active, 1);
      end
    end
    check("hsync_cnt", hs_cnt, 32);
    check("hsync_first", hs_first, 45);
    check("hsync_last", hs_last, 76);
    check("hblank_cnt", hb_cnt, 80);
    check("go_cnt", go_cnt, 32);
    check("go_first", go_first, 128);
    check("go_last", go_last, 376);
    check("mem_z_outside", mz_low, 32);
    check("mem_z_window", mz_win, 31);
    check("io_z", io_z, 48);
    check("pos_wrap", {7'd0, bus_ac.vc, 7'd0, bus_ac.hc}, {16'd1, 16'd0});
    check("fa_at_hc0", bus_ac.fetch_active, 1);

    // Line 1: screen off and full contention
    ce_div = 1; soff = 1'b1; full_contend = 1'b1;
    go_cnt = 0; go_first = -1; fz = 0;
    for (int k = 0; k < 384; k++) begin
      pix(2'b00);
      if (k == 0) check("fa_cleared", bus_ac.fetch_active, 0);
      if (pos_v == 1 && pos_h <= 127 && !bus_ac.mem_contention) fz++;
    end
    soff = 1'b0; full_contend = 1'b0;
    check("soff_go_cnt", go_cnt, 0);
    check("soff_fa", bus_ac.fetch_active, 0);
    check("full_mem_z", fz, 16);
    check("hpen_soff", bus_ac.hpen, 12);

    // Line 2: light pen latches
    goto(60, 2); paper = 1'b1;
    goto(70, 2);  check("lpen_hc69", bus_ac.lpen, 8'hC0);
    check("hpen_vc2", bus_ac.hpen, 2);
    goto(134, 2); check("lpen_hc133", bus_ac.lpen, 8'h00);
    goto(166, 2); check("lpen_hc165", bus_ac.lpen, 8'h20);
    paper = 1'b0;
    goto(174, 2); check("lpen_nopaper", bus_ac.lpen, 8'h00);

    // Line interrupt written on the previous line
    goto(200, 4); write_line(8'd5);
    goto(0, 5);   check("lint_pre_ac", bus_ac.int_pending, 2'b00);
    goto(1, 5);   check("lint_set_ac", bus_ac.int_pending, 2'b01);
    check("lint_set_hold", bus_hold.int_pending, 2'b01);
    goto(128, 5); check("lint_hold128_ac", bus_ac.int_pending, 2'b01);
    goto(129, 5); check("lint_autoclr_ac", bus_ac.int_pending, 2'b00);
    check("lint_noauto_hold", bus_hold.int_pending, 2'b01);
    ack(2'b01);   check("lint_ack_hold", bus_hold.int_pending, 2'b00);

    // Mid-line write of the current line: no interrupt this frame
    goto(50, 8);  write_line(8'd8);
    goto(1, 9);   check("lint_midline_hold", bus_hold.int_pending, 2'b00);

    goto(6, 13);  check("hpen_vblank", bus_ac.hpen, 12);
    goto(28, 14); check("vblank_pre", bus_ac.vblank, 0);
    goto(29, 14); check("vblank_rise", bus_ac.vblank, 1);
    goto(383, 14); check("vsync_pre", bus_ac.vsync, 0);
    goto(0, 15);  check("vsync_rise", bus_ac.vsync, 1);
    goto(383, 15); check("vsync_hi", bus_ac.vsync, 1);
    goto(0, 16);  check("vsync_fall", bus_ac.vsync, 0);
    check("fint_pre", bus_hold.int_pending, 2'b00);
    goto(1, 16);  check("fint_set_ac", bus_ac.int_pending, 2'b10);
    check("fint_set_hold", bus_hold.int_pending, 2'b10);
    goto(129, 16); check("fint_autoclr_ac", bus_ac.int_pending, 2'b00);
    check("fint_held_hold", bus_hold.int_pending, 2'b10);
    goto(1, 17);  check("fint_held_next", bus_hold.int_pending, 2'b10);
    ack(2'b10);   check("fint_ack_hold", bus_hold.int_pending, 2'b00);
    goto(104, 17); check("vblank_hi", bus_ac.vblank, 1);
    goto(105, 17); check("vblank_fall", bus_ac.vblank, 0);
    goto(383, 19); check("flash_f0_hold", bus_hold.flash, 0);
    goto(0, 0);   check("flash_f1_hold", bus_hold.flash, 1);
    check("flash_f1_ac", bus_ac.flash, 0);

    // Frame 1: deferred line interrupt, disable, coincident ack
    goto(0, 8);   check("lint_f1_pre", bus_hold.int_pending, 2'b00);
    goto(1, 8);   check("lint_f1_hold", bus_hold.int_pending, 2'b01);
    check("lint_f1_ac", bus_ac.int_pending, 2'b01);
    ack(2'b01);
    goto(10, 9);  write_line(8'd255);
    goto(0, 16);  pix(2'b10);
    check("fint_ack_coinc_hold", bus_hold.int_pending, 2'b10);
    ack(2'b10);   check("fint_ack2_hold", bus_hold.int_pending, 2'b00);
    goto(0, 0);   check("flash_f2_hold", bus_hold.flash, 0);
    check("flash_f2_ac", bus_ac.flash, 1);

    // Frame 2: line compare 255 never fires, then asynchronous reset
    goto(1, 8);   check("lint_255_hold", bus_hold.int_pending, 2'b00);
    check("lint_255_ac", bus_ac.int_pending, 2'b00);
    goto(200, 8);
    #2 reset = 1'b1;
    #1;
    check("arst_hc", bus_ac.hc, 0);
    check("arst_vc", bus_ac.vc, 0);
    check("arst_flash", bus_ac.flash, 0);
    check("arst_hpen", bus_ac.hpen, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    pos_h = 0; pos_v = 0;
    goto(1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
